// File: rtl/rv_bus_pkg.sv
// rtl/rv_bus_pkg.sv - shared types and constants for the picorv32 memory arbiter
package rv_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MEM,
        ST_IO_WAIT,
        ST_FAULT,
        ST_RESP
    } bus_state_t;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_LDR  = 1'b1
    } req_id_t;

    typedef enum logic [1:0] {
        REGION_MEM,
        REGION_IO,
        REGION_FAULT
    } region_t;

    localparam logic [31:0] DEFAULT_IO_BASE = 32'h1000_0000;
    localparam logic [31:0] DEFAULT_IO_MASK = 32'hF000_0000;
    localparam logic [31:0] FAULT_RDATA     = 32'h0000_0000;

endpackage

// File: rtl/rv_addr_decode.sv
// rtl/rv_addr_decode.sv - maps an address and requester to memory, IO or fault
module rv_addr_decode
    import rv_bus_pkg::*;
#(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] IO_BASE = DEFAULT_IO_BASE,
    parameter logic [31:0] IO_MASK = DEFAULT_IO_MASK
) (
    input  logic [31:0] addr,
    input  req_id_t     rid,
    output region_t     region
);

    // Only the core may reach the IO window; the loader targets main memory only.
    always_comb begin
        region = REGION_FAULT;
        if (addr[31:ADDR_W+2] == '0) begin
            region = REGION_MEM;
        end else if ((rid == REQ_CORE) && ((addr & IO_MASK) == IO_BASE)) begin
            region = REGION_IO;
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// rtl/rv_mem_arbiter.sv - round-robin core/loader arbiter for main BRAM and the IO window
module rv_mem_arbiter
    import rv_bus_pkg::*;
#(
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] IO_BASE    = DEFAULT_IO_BASE,
    parameter logic [31:0] IO_MASK    = DEFAULT_IO_MASK,
    parameter int          IO_TIMEOUT = 255,
    localparam int         ADDR_W     = $clog2(MEM_WORDS)
) (
    input  logic              picorv_clk,
    input  logic              reset,
    input  logic              core_valid,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    input  logic [3:0]        core_wstrb,
    output logic [31:0]       core_rdata,
    output logic              core_ready,
    input  logic              ldr_valid,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    output logic              io_valid,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    output logic [3:0]        io_wstrb,
    input  logic [31:0]       io_rdata,
    input  logic              io_ready,
    output logic              bus_fault,
    output logic [31:0]       fault_addr
);

    localparam int              TO_W    = (IO_TIMEOUT < 1) ? 1 : $clog2(IO_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IO_TIMEOUT);

    bus_state_t      state, state_next;
    req_id_t         rid_q, last_q, gnt_id;
    logic            gnt_valid;
    logic [31:0]     req_addr;
    region_t         req_region;
    logic [31:0]     addr_q, wdata_q, rdata_q, io_rdata_q, fault_addr_q;
    logic [3:0]      wstrb_q;
    logic            io_valid_q, io_ready_q, bus_fault_q;
    logic [TO_W-1:0] to_cnt;

    // Tie goes to whoever was not served last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = REQ_CORE;
        if (core_valid && ldr_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = (last_q == REQ_CORE) ? REQ_LDR : REQ_CORE;
        end else if (ldr_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = REQ_LDR;
        end else if (core_valid) begin
            gnt_valid = 1'b1;
            gnt_id    = REQ_CORE;
        end
    end

    assign req_addr = (gnt_id == REQ_LDR) ? ldr_addr : core_addr;

    rv_addr_decode #(
        .ADDR_W  (ADDR_W),
        .IO_BASE (IO_BASE),
        .IO_MASK (IO_MASK)
    ) u_addr_decode (
        .addr   (req_addr),
        .rid    (gnt_id),
        .region (req_region)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    case (req_region)
                        REGION_MEM: state_next = ST_MEM;
                        REGION_IO:  state_next = ST_IO_WAIT;
                        default:    state_next = ST_FAULT;
                    endcase
                end
            end
            ST_MEM:     state_next = ST_RESP;
            ST_IO_WAIT: begin
                if (io_ready_q) begin
                    state_next = ST_RESP;
                end else if (to_cnt == TO_LAST) begin
                    state_next = ST_FAULT;
                end
            end
            ST_FAULT:   state_next = ST_RESP;
            ST_RESP:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge picorv_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // io_ready is registered; io_valid drops the cycle after the handshake.
    always_ff @(posedge picorv_clk) begin
        if (reset) begin
            rid_q        <= REQ_CORE;
            last_q       <= REQ_CORE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            io_rdata_q   <= '0;
            io_valid_q   <= 1'b0;
            io_ready_q   <= 1'b0;
            to_cnt       <= '0;
            bus_fault_q  <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            io_valid_q <= (state_next == ST_IO_WAIT) && !(io_valid_q && io_ready);
            io_ready_q <= (state == ST_IO_WAIT) && io_valid_q && io_ready;
            if ((state == ST_IO_WAIT) && io_valid_q && io_ready) begin
                io_rdata_q <= io_rdata;
            end
            to_cnt <= (state == ST_IO_WAIT) ? to_cnt + 1'b1 : '0;

            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        rid_q   <= gnt_id;
                        addr_q  <= req_addr;
                        wdata_q <= (gnt_id == REQ_LDR) ? ldr_wdata : core_wdata;
                        wstrb_q <= (gnt_id == REQ_LDR) ? 4'hF : core_wstrb;
                    end
                end
                ST_MEM: begin
                    if (rid_q == REQ_CORE) begin
                        rdata_q <= mem_rdata;
                    end
                end
                ST_IO_WAIT: begin
                    if (io_ready_q) begin
                        rdata_q <= io_rdata_q;
                    end
                end
                ST_FAULT: begin
                    bus_fault_q <= 1'b1;
                    if (!bus_fault_q) begin
                        fault_addr_q <= addr_q;
                    end
                    if (rid_q == REQ_CORE) begin
                        rdata_q <= FAULT_RDATA;
                    end
                end
                ST_RESP: last_q <= rid_q;
                default: ;
            endcase
        end
    end

    assign core_ready = (state == ST_RESP) && (rid_q == REQ_CORE);
    assign ldr_ready  = (state == ST_RESP) && (rid_q == REQ_LDR);
    assign core_rdata = rdata_q;
    assign mem_addr   = addr_q[ADDR_W+1:2];
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = (state == ST_MEM) ? wstrb_q : 4'h0;
    assign io_valid   = io_valid_q;
    assign io_addr    = addr_q;
    assign io_wdata   = wdata_q;
    assign io_wstrb   = io_valid_q ? wstrb_q : 4'h0;
    assign bus_fault  = bus_fault_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb/tb_rv_mem_arbiter.sv - scoreboard bench for rv_mem_arbiter
module tb_rv_mem_arbiter;

    localparam int AW = 12;

    logic          picorv_clk = 1'b0;
    logic          reset;
    logic          core_valid, ldr_valid, io_ready, core_ready, ldr_ready;
    logic [31:0]   core_addr, core_wdata, ldr_addr, ldr_wdata, core_rdata;
    logic [3:0]    core_wstrb, mem_wstrb, io_wstrb;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata, io_addr, io_wdata, io_rdata, fault_addr;
    logic          io_valid, bus_fault;

    rv_mem_arbiter dut (
        .picorv_clk (picorv_clk),
        .reset      (reset),
        .core_valid (core_valid),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_wstrb (core_wstrb),
        .core_rdata (core_rdata),
        .core_ready (core_ready),
        .ldr_valid  (ldr_valid),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_ready  (ldr_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .io_valid   (io_valid),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_wstrb   (io_wstrb),
        .io_rdata   (io_rdata),
        .io_ready   (io_ready),
        .bus_fault  (bus_fault),
        .fault_addr (fault_addr)
    );

    always #5 picorv_clk = ~picorv_clk;

    int cyc = 0;
    always @(posedge picorv_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // BRAM model on the inverted clock, read-before-write
    logic [31:0] mem [0:4095];
    int          wr_cnt8 = 0;
    initial for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    always @(negedge picorv_clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wstrb != 4'h0) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr][b*8 +: 8] = mem_wdata[b*8 +: 8];
            if (mem_addr == 12'd8) wr_cnt8++;
        end
    end

    // IO responder: io_ready after io_delay extra cycles of io_valid; never when negative
    int          io_delay = -1;
    int          io_cnt = 0;
    int          io_cycles = 0;
    logic [31:0] io_resp = 32'h0;
    logic [31:0] io_exp_addr = 32'h0;
    initial begin
        io_ready = 1'b0;
        io_rdata = 32'h0;
        forever begin
            @(posedge picorv_clk);
            #1;
            io_ready = 1'b0;
            if (io_valid) begin
                check("io_addr_stable", io_addr, io_exp_addr);
                io_cnt++;
                io_cycles++;
                if (io_delay >= 0 && io_cnt == io_delay + 1) begin
                    io_ready = 1'b1;
                    io_rdata = io_resp;
                end
            end else begin
                io_cnt = 0;
            end
        end
    end

    typedef struct {
        bit          is_ldr;
        bit          chk_rd;
        logic [31:0] rdata;
        int          due;
    } exp_t;
    exp_t sb[$];

    always @(negedge picorv_clk) begin
        if (core_ready || ldr_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", {30'h0, ldr_ready, core_ready}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ready_src", 32'(ldr_ready), 32'(e.is_ldr));
                check("ready_cycle", cyc, e.due);
                if (!e.is_ldr && e.chk_rd) check("core_rdata", core_rdata, e.rdata);
            end
        end
    end

    task automatic step();
        @(posedge picorv_clk);
        #1;
    endtask

    task automatic start_req(input bit is_ldr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws, input bit chk_rd, input logic [31:0] exp_rd,
                             input int lat);
        exp_t e;
        e.is_ldr = is_ldr;
        e.chk_rd = chk_rd;
        e.rdata  = exp_rd;
        e.due    = cyc + lat;
        sb.push_back(e);
        if (is_ldr) begin
            ldr_valid = 1'b1; ldr_addr = a; ldr_wdata = wd;
        end else begin
            core_valid = 1'b1; core_addr = a; core_wdata = wd; core_wstrb = ws;
        end
    endtask

    task automatic wait_done(input bit is_ldr);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge picorv_clk);
            seen = is_ldr ? ldr_ready : core_ready;
        end
        check("req_done", 32'(seen), 32'd1);
        step();
        if (is_ldr) ldr_valid = 1'b0;
        else core_valid = 1'b0;
    endtask

    // Both requesters valid back to back; loader writes, core reads 0x10
    task automatic run_both(input int n);
        int  c0, ldr_left, core_left, guard;
        bit  sl, sc;
        exp_t e;
        c0 = cyc;
        for (int k = 0; k < n; k++) begin
            e.is_ldr = (k % 2 == 0);
            e.chk_rd = 1'b1;
            e.rdata  = 32'hDEADBEEF;
            e.due    = c0 + 2 + 3 * k;
            sb.push_back(e);
        end
        ldr_left  = (n + 1) / 2;
        core_left = n / 2;
        ldr_valid = 1'b1; ldr_addr = 32'h40; ldr_wdata = 32'hC0DE0000;
        core_valid = 1'b1; core_addr = 32'h10; core_wdata = 32'h0; core_wstrb = 4'h0;
        guard = 0;
        while ((ldr_left > 0 || core_left > 0) && guard < 100) begin
            @(negedge picorv_clk);
            sl = ldr_ready;
            sc = core_ready;
            step();
            guard++;
            if (sl) begin
                ldr_left--;
                if (ldr_left == 0) ldr_valid = 1'b0;
                ldr_addr  = ldr_addr + 32'h4;
                ldr_wdata = ldr_wdata + 32'h1;
            end
            if (sc) begin
                core_left--;
                if (core_left == 0) core_valid = 1'b0;
            end
        end
        check("contention_done", 32'(ldr_left + core_left), 32'd0);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_core_rdata"}, core_rdata, 32'h0);
        check({pfx, "_core_ready"}, 32'(core_ready), 32'h0);
        check({pfx, "_ldr_ready"}, 32'(ldr_ready), 32'h0);
        check({pfx, "_mem_addr"}, 32'(mem_addr), 32'h0);
        check({pfx, "_mem_wdata"}, mem_wdata, 32'h0);
        check({pfx, "_mem_wstrb"}, 32'(mem_wstrb), 32'h0);
        check({pfx, "_io_valid"}, 32'(io_valid), 32'h0);
        check({pfx, "_io_addr"}, io_addr, 32'h0);
        check({pfx, "_io_wstrb"}, 32'(io_wstrb), 32'h0);
        check({pfx, "_bus_fault"}, 32'(bus_fault), 32'h0);
        check({pfx, "_fault_addr"}, fault_addr, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        core_valid = 1'b0; core_addr = 32'h0; core_wdata = 32'h0; core_wstrb = 4'h0;
        ldr_valid = 1'b0; ldr_addr = 32'h0; ldr_wdata = 32'h0;
        repeat (3) step();
        check_zero("rst");
        reset = 1'b0;
        step();

        // loader write then core read of the same word
        start_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 2);
        wait_done(1'b1);
        start_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 2);
        step();
        check("mem_addr_rd", 32'(mem_addr), 32'd4);
        check("mem_wstrb_rd", 32'(mem_wstrb), 32'h0);
        wait_done(1'b0);

        // byte-lane write
        start_req(1'b1, 32'h4, 32'h11223344, 4'hF, 1'b0, 32'h0, 2);
        wait_done(1'b1);
        start_req(1'b0, 32'h4, 32'h0000AB00, 4'b0010, 1'b0, 32'h0, 2);
        step();
        check("mem_wstrb_wr", 32'(mem_wstrb), 32'h2);
        wait_done(1'b0);
        start_req(1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 32'h1122AB44, 2);
        wait_done(1'b0);

        // six contended transactions
        run_both(6);

        // IO read with delayed ready
        io_delay = 5; io_resp = 32'h5A; io_exp_addr = 32'h1000_0008; io_cycles = 0;
        start_req(1'b0, 32'h1000_0008, 32'h0, 4'h0, 1'b1, 32'h5A, 8);
        wait_done(1'b0);
        check("io_valid_cycles", io_cycles, 32'd6);

        // unmapped access, then IO timeout
        start_req(1'b0, 32'h2000_0000, 32'h0, 4'h0, 1'b1, 32'h0, 2);
        wait_done(1'b0);
        check("bus_fault_set", 32'(bus_fault), 32'd1);
        check("fault_addr_first", fault_addr, 32'h2000_0000);
        io_delay = -1; io_exp_addr = 32'h1000_0000; io_cycles = 0;
        start_req(1'b0, 32'h1000_0000, 32'h0, 4'h0, 1'b1, 32'h0, 258);
        wait_done(1'b0);
        check("io_timeout_cycles", io_cycles, 32'd256);
        check("fault_addr_sticky", fault_addr, 32'h2000_0000);

        // loader outside memory faults without reaching IO
        start_req(1'b1, 32'h1000_0000, 32'h12345678, 4'hF, 1'b0, 32'h0, 2);
        wait_done(1'b1);
        check("ldr_fault_no_io", io_cycles, 32'd256);
        check("fault_addr_ldr", fault_addr, 32'h2000_0000);

        // reset during a MEM write, after a loader grant
        start_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 2);
        wait_done(1'b0);
        start_req(1'b1, 32'h30, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 2);
        wait_done(1'b1);
        wr_cnt8 = 0;
        core_valid = 1'b1; core_addr = 32'h20; core_wdata = 32'h77; core_wstrb = 4'hF;
        step();
        reset = 1'b1;
        core_valid = 1'b0;
        step();
        check_zero("midrst");
        reset = 1'b0;
        repeat (2) step();
        check("mem_write_once", wr_cnt8, 32'd1);
        check("mem_word8", mem[8], 32'h77);
        run_both(2);

        repeat (3) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_mem_arbiter.md
# rv_mem_arbiter

Shares the single main block RAM between the picorv32 native memory interface and the code-loader word port, and routes core accesses in the IO window to the IO port. It sits between the core, the loader logic fed by the code FIFO, and main memory, all in the `picorv_clk` domain. It runs one transaction at a time, arbitrates round-robin and decodes addresses. Unmapped or timed-out accesses are terminated with a fault record so the core never hangs.

## Interface
Parameters:
- `MEM_WORDS`, 4096: main memory depth in 32-bit words; power of two; `ADDR_W = $clog2(MEM_WORDS)`.
- `IO_BASE`, 32'h1000_0000: IO window base.
- `IO_MASK`, 32'hF000_0000: address is in the IO window when `(addr & IO_MASK) == IO_BASE`.
- `IO_TIMEOUT`, 255: maximum number of IO_WAIT cycles before a fault.

Ports:
- `picorv_clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `core_valid` in 1 / `core_addr` in 32 / `core_wdata` in 32 / `core_wstrb` in 4: core request; `core_wstrb == 0` means read.
- `core_rdata` out 32 / `core_ready` out 1: core response.
- `ldr_valid` in 1 / `ldr_addr` in 32 / `ldr_wdata` in 32: loader request; write-only, full word.
- `ldr_ready` out 1: loader completion.
- `mem_addr` out ADDR_W / `mem_wdata` out 32 / `mem_wstrb` out 4: BRAM word address, write data, byte enables.
- `mem_rdata` in 32: BRAM read data.
- `io_valid` out 1 / `io_addr` out 32 / `io_wdata` out 32 / `io_wstrb` out 4: IO request.
- `io_rdata` in 32 / `io_ready` in 1: IO response.
- `bus_fault` out 1: sticky fault flag.
- `fault_addr` out 32: address of the first faulting access.

## Operation
- States: IDLE, MEM, IO_WAIT, FAULT, RESP.
- IDLE, arbitration:
  - With one requester valid, grant it.
  - With both valid, grant the one not granted last. The last-grant register resets to "core", so the loader wins the first tie.
- IDLE, capture: on grant, register addr, wdata, wstrb (loader always 4'hF) and the requester id. Decode the registered address in the same cycle and select the next state:
  - `addr[31:ADDR_W+2] == 0`: MEM.
  - Core access in the IO window: IO_WAIT.
  - Anything else, including any loader access outside memory: FAULT.
- MEM, one cycle:
  - `mem_addr = addr[ADDR_W+1:2]`, `mem_wstrb` = registered strobe.
  - Read data is sampled from `mem_rdata` at the end of this cycle; BRAM is clocked on the inverted clock.
  - Next state: RESP.
- IO_WAIT:
  - `io_valid` is held with stable addr/wdata/wstrb until `io_ready`.
  - On `io_ready`: capture `io_rdata`, go to RESP.
  - The timeout counter runs from 0. When it reaches `IO_TIMEOUT` without `io_ready`, drop `io_valid` and go to FAULT.
- FAULT, one cycle:
  - Set `bus_fault`. Load `fault_addr` only if `bus_fault` was 0.
  - Read data is forced to 32'h0. Next state: RESP.
- RESP, one cycle:
  - Assert the granted requester's ready: `core_ready` with `core_rdata`, or `ldr_ready`.
  - Update the last-grant register. Next state: IDLE.
- The arbiter never re-samples a request in RESP. Requesters drop valid or present a new request on the edge at which they see ready.
- Faulted writes are discarded; memory is not modified.

## Timing
- Reset values: all outputs 0, state IDLE, last-grant = core, `bus_fault` = 0, `fault_addr` = 0.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Reset mid-transaction: next cycle all outputs are 0 and the FSM is in IDLE. The in-flight transaction is dropped with no ready.
- Latency, valid first seen in cycle 0:
  - Memory read/write: ready in cycle 2.
  - IO: ready 2 cycles after the cycle in which `io_ready` is sampled.
  - Unmapped access: ready in cycle 2.
  - IO timeout: ready in cycle `IO_TIMEOUT+3`.
- Outside MEM, `mem_wstrb` = 0. Outside IO_WAIT, `io_valid` = 0.
- `core_rdata` holds its value after RESP. `core_ready` and `ldr_ready` are single-cycle pulses.
- Throughput: one transaction per 3 cycles. Under continuous contention, requesters alternate strictly.

## Structure
- Package `rv_bus_pkg`: state enum, requester-id enum, default `IO_BASE`/`IO_MASK` constants, fault read value.
- Sub-module `rv_addr_decode`: combinational; maps (addr, requester id) to one of {MEM, IO, FAULT}. It is reused by the future MMIO peripherals.
- The top-level wrapper ties `ldr_*` to the loader logic fed by the code FIFO and `io_*` to the LED/switch/serial peripherals.

## Test plan
- Loader writes 32'hDEADBEEF to 0x0000_0010, then core reads 0x0000_0010 → `mem_addr` = 4, `core_rdata` = 32'hDEADBEEF, `core_ready` 2 cycles after `core_valid`.
- Core writes `wstrb` = 4'b0010, data 32'h0000AB00, to 0x0000_0004 over 32'h11223344 → subsequent read returns 32'h1122AB44.
- Core and loader both valid for 6 consecutive transactions → grants alternate ldr, core, ldr, core, ldr, core; each ready lands 3 cycles apart.
- Core reads 0x1000_0008 with `io_ready` delayed 5 cycles, `io_rdata` = 32'h5A → `io_valid` stable throughout, `core_rdata` = 32'h5A.
- Core reads 0x2000_0000, then 0x1000_0000 with `io_ready` never asserted (`IO_TIMEOUT` = 255) → first: `bus_fault` = 1, `fault_addr` = 32'h2000_0000, rdata 0 at cycle 2. Second: ready at cycle 258, `fault_addr` unchanged.
- `reset` asserted in the cycle after a MEM write grant → no `core_ready`, memory write of that transaction not repeated, all outputs 0 next cycle, loader wins the next tie.
